// File: rtl/calc_op_sequencer_if.sv
// calc_op_sequencer_if
// Request/response handshake between the calculator sequencer and the shared
// multi-cycle arithmetic unit.
//   alu_start  : one-cycle request pulse (sequencer -> ALU)
//   alu_op     : 0 add, 1 sub, 2 mul, 3 div
//   alu_a/b    : binary operands 0..99, stable while a request is outstanding
//   alu_done   : one-cycle completion pulse (ALU -> sequencer)
//   alu_result : result magnitude, valid with alu_done
//   alu_neg    : result sign, valid with alu_done
interface calc_op_sequencer_if;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [6:0]  alu_a;
  logic [6:0]  alu_b;
  logic        alu_done;
  logic [13:0] alu_result;
  logic        alu_neg;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_done, alu_result, alu_neg
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_done, alu_result, alu_neg
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Turns switch rising edges into calculator commands, holds two 2-digit BCD
// operands, issues one ALU request at a time and converts the binary result to
// four display digits with a one-bit-per-cycle double-dabble pass.
//   clk, reset      : clock, synchronous active-high reset
//   sw[8:0]         : switch levels; rising edge = command (sw[8] highest priority)
//   alu             : ALU handshake (master side)
//   digit3..digit0  : display digits, digit3 = MSD; 4'hF minus, 4'hE error glyph
//   dot             : 1 operand view, 0 result view
//   busy            : request in flight or conversion running
//   err             : sticky error until the next accepted command
//
// state  | meaning
// IDLE   | waiting for a command edge
// ISSUE  | alu_start high for this single cycle
// WAIT   | waiting for alu_done, timeout counter running
// CONV   | 14 double-dabble iterations on the captured result
module calc_op_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] sw,
  calc_op_sequencer_if.master alu,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       dot,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CONV} state_t;

  localparam logic [15:0] ERR_GLYPH = 16'hEEEE;

  state_t      state_q, state_d;
  logic [8:0]  sw_q, sw_d;
  logic [3:0]  a_t_q, a_t_d, a_u_q, a_u_d, b_t_q, b_t_d, b_u_q, b_u_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        start_q, start_d;
  logic [15:0] cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        neg_q, neg_d, ovf_q, ovf_d;
  logic [15:0] dig_q, dig_d;
  logic        dot_q, dot_d, err_q, err_d;

  logic [8:0]  rise;
  logic [15:0] bcd_adj, bcd_sh;
  logic [6:0]  a_val, b_val;
  logic        view;

  function automatic logic [3:0] inc_bcd(input logic [3:0] v);
    return (v == 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    sw_d    = sw;
    a_t_d   = a_t_q;
    a_u_d   = a_u_q;
    b_t_d   = b_t_q;
    b_u_d   = b_u_q;
    op_d    = op_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    dot_d   = dot_q;
    err_d   = err_q;
    view    = 1'b0;

    rise  = sw & ~sw_q;
    a_val = 7'(a_t_q) * 7'd10 + 7'(a_u_q);
    b_val = 7'(b_t_q) * 7'd10 + 7'(b_u_q);

    // add-3 correction on every nibble >= 5, then shift one binary bit in
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[14:0], bin_q[13]};

    case (state_q)
      S_IDLE: begin
        if (rise[8])      begin a_t_d = inc_bcd(a_t_q); view = 1'b1; end
        else if (rise[7]) begin a_u_d = inc_bcd(a_u_q); view = 1'b1; end
        else if (rise[6]) begin b_t_d = inc_bcd(b_t_q); view = 1'b1; end
        else if (rise[5]) begin b_u_d = inc_bcd(b_u_q); view = 1'b1; end
        else if (|rise[4:1]) begin
          if (rise[1] && !(|rise[4:2]) && b_val == 7'd0) begin
            dig_d = ERR_GLYPH;
            dot_d = 1'b0;
            err_d = 1'b1;
          end else begin
            op_d    = rise[4] ? 2'd0 : rise[3] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
            alu_a_d = a_val;
            alu_b_d = b_val;
            err_d   = 1'b0;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
        else if (rise[0]) view = 1'b1;

        if (view) begin
          dig_d = {a_t_d, a_u_d, b_t_d, b_u_d};
          dot_d = 1'b1;
          err_d = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'(ALU_TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu.alu_done) begin
          bin_d   = alu.alu_result;
          bcd_d   = 16'd0;
          iter_d  = 4'd0;
          neg_d   = alu.alu_neg;
          ovf_d   = alu.alu_result > 14'd9999;
          state_d = S_CONV;
        end else if (cnt_q == 16'd0) begin
          dig_d   = ERR_GLYPH;
          dot_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CONV: begin
        bcd_d  = bcd_sh;
        bin_d  = {bin_q[12:0], 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) begin
          dot_d   = 1'b0;
          state_d = S_IDLE;
          if (ovf_q) begin
            dig_d = ERR_GLYPH;
            err_d = 1'b1;
          end else if (neg_q) begin
            dig_d = {4'hF, bcd_sh[11:0]};
          end else begin
            dig_d = bcd_sh;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sw_q    <= 9'h1FF;
      a_t_q   <= 4'd0;
      a_u_q   <= 4'd0;
      b_t_q   <= 4'd0;
      b_u_q   <= 4'd0;
      op_q    <= 2'd0;
      alu_a_q <= 7'd0;
      alu_b_q <= 7'd0;
      start_q <= 1'b0;
      cnt_q   <= 16'd0;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      iter_q  <= 4'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= 16'd0;
      dot_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      a_t_q   <= a_t_d;
      a_u_q   <= a_u_d;
      b_t_q   <= b_t_d;
      b_u_q   <= b_u_d;
      op_q    <= op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
      dot_q   <= dot_d;
      err_q   <= err_d;
    end
  end

  assign alu.alu_start = start_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_a     = alu_a_q;
  assign alu.alu_b     = alu_b_q;
  assign digit3 = dig_q[15:12];
  assign digit2 = dig_q[11:8];
  assign digit1 = dig_q[7:4];
  assign digit0 = dig_q[3:0];
  assign dot    = dot_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] sw = '0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       dot, busy, err;

  calc_op_sequencer_if bus();

  calc_op_sequencer #(.ALU_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .sw(sw), .alu(bus),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dot(dot), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_at, m_au, m_bt, m_bu;
  logic [15:0] m_dig;
  logic        m_dot, m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag);
    chk({tag, "_digits"}, {16'd0, digit3, digit2, digit1, digit0}, {16'd0, m_dig});
    chk({tag, "_dot"}, {31'd0, dot}, {31'd0, m_dot});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic model_view();
    m_dig = {m_at[3:0], m_au[3:0], m_bt[3:0], m_bu[3:0]};
    m_dot = 1'b1;
    m_err = 1'b0;
  endtask

  task automatic model_reset();
    m_at = 0; m_au = 0; m_bt = 0; m_bu = 0;
    m_dig = 16'h0000; m_dot = 1'b1; m_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_disp(tag);
    chk({tag, "_start"}, {31'd0, bus.alu_start}, 32'd0);
    chk({tag, "_op"}, {30'd0, bus.alu_op}, 32'd0);
    chk({tag, "_a"}, {25'd0, bus.alu_a}, 32'd0);
    chk({tag, "_b"}, {25'd0, bus.alu_b}, 32'd0);
  endtask

  task automatic press(input int idx);
    sw[idx] = 1'b1;
    tick();
    case (idx)
      8: m_at = (m_at + 1) % 10;
      7: m_au = (m_au + 1) % 10;
      6: m_bt = (m_bt + 1) % 10;
      5: m_bu = (m_bu + 1) % 10;
      default: ;
    endcase
    model_view();
    check_disp($sformatf("press%0d", idx));
    sw[idx] = 1'b0;
    tick();
  endtask

  task automatic set_operands(input int at, input int au, input int bt, input int bu);
    repeat ((at - m_at + 10) % 10) press(8);
    repeat ((au - m_au + 10) % 10) press(7);
    repeat ((bt - m_bt + 10) % 10) press(6);
    repeat ((bu - m_bu + 10) % 10) press(5);
  endtask

  // arithmetic as the ALU defines it; div rounds half-up
  task automatic alu_model(input int op, input int a, input int b, output int mag, output bit neg);
    neg = 1'b0;
    case (op)
      0: mag = a + b;
      1: begin mag = (a >= b) ? a - b : b - a; neg = (a < b); end
      2: mag = a * b;
      default: mag = (2 * a + b) / (2 * b);
    endcase
  endtask

  task automatic model_result(input int mag, input bit neg);
    m_dot = 1'b0;
    m_err = 1'b0;
    if (mag > 9999) begin
      m_dig = 16'hEEEE;
      m_err = 1'b1;
    end else if (neg) begin
      m_dig = {4'hF, 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
    end else begin
      m_dig = {4'((mag / 1000) % 10), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
    end
  endtask

  task automatic do_op(input int op, input int lat, input bit toggle7, input int force_res);
    int a, b, mag, n, starts;
    bit neg;
    a = 10 * m_at + m_au;
    b = 10 * m_bt + m_bu;
    alu_model(op, a, b, mag, neg);
    if (force_res >= 0) mag = force_res;
    sw[4 - op] = 1'b1;
    tick();
    sw[4 - op] = 1'b0;
    chk("issue_start", {31'd0, bus.alu_start}, 32'd1);
    chk("issue_op", {30'd0, bus.alu_op}, 32'(op));
    chk("issue_a", {25'd0, bus.alu_a}, 32'(a));
    chk("issue_b", {25'd0, bus.alu_b}, 32'(b));
    chk("issue_busy", {31'd0, busy}, 32'd1);
    chk("issue_digits_held", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, m_dig});
    for (int k = 0; k < lat; k++) begin
      if (toggle7) sw[7] = (k == 0);
      tick();
      chk("wait_start_low", {31'd0, bus.alu_start}, 32'd0);
      chk("wait_a_held", {25'd0, bus.alu_a}, 32'(a));
    end
    sw[7] = 1'b0;
    bus.alu_done = 1'b1;
    bus.alu_result = 14'(mag);
    bus.alu_neg = neg;
    tick();
    bus.alu_done = 1'b0;
    bus.alu_result = 14'($urandom);
    bus.alu_neg = 1'b0;
    n = 0;
    starts = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.alu_start === 1'b1) starts++;
    end
    chk("conv_cycles", 32'(n), 32'd14);
    chk("extra_starts", 32'(starts), 32'd0);
    model_result(mag, neg);
    check_disp($sformatf("result_op%0d", op));
  endtask

  initial begin
    int n, op;
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
    bus.alu_neg = 1'b0;
    model_reset();

    // reset with sw[8] held: must not fire on release
    sw[8] = 1'b1;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
    check_disp("held_through_reset");
    sw[8] = 1'b0;
    tick();

    // operand entry
    set_operands(3, 4, 1, 2);
    chk("operand_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h3412);
    repeat (10) press(8);

    // add 34+12
    do_op(0, 3, 1'b0, -1);
    chk("add_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0046);

    // sub 12-34 -> -22, with sw[7] toggled during WAIT
    set_operands(1, 2, 3, 4);
    do_op(1, 3, 1'b1, -1);
    press(0);

    // mul 99*99
    set_operands(9, 9, 9, 9);
    do_op(2, 2, 1'b0, -1);

    // overflow result
    do_op(0, 1, 1'b0, 10000);

    // divide by zero
    set_operands(4, 5, 0, 0);
    sw[1] = 1'b1;
    tick();
    sw[1] = 1'b0;
    chk("div0_start", {31'd0, bus.alu_start}, 32'd0);
    m_dig = 16'hEEEE; m_dot = 1'b0; m_err = 1'b1;
    check_disp("div0");
    tick();
    press(0);

    // simultaneous sw[8] and sw[5]: only a_t increments
    sw[8] = 1'b1;
    sw[5] = 1'b1;
    tick();
    m_at = (m_at + 1) % 10;
    model_view();
    check_disp("simul_rise");
    sw = '0;
    tick();

    // timeout
    set_operands(2, 0, 0, 7);
    sw[4] = 1'b1;
    tick();
    sw[4] = 1'b0;
    chk("to_start", {31'd0, bus.alu_start}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(T + 1));
    m_dig = 16'hEEEE; m_dot = 1'b0; m_err = 1'b1;
    check_disp("timeout");
    bus.alu_done = 1'b1;
    bus.alu_result = 14'd55;
    tick();
    bus.alu_done = 1'b0;
    tick();
    check_disp("late_done");

    // randomized operations
    for (int i = 0; i < 8; i++) begin
      set_operands($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      op = $urandom_range(0, 3);
      if (op == 3 && m_bt == 0 && m_bu == 0) press(5);
      do_op(op, $urandom_range(1, 6), 1'b0, -1);
    end

    // reset during CONV, then stale done
    set_operands(5, 6, 7, 8);
    sw[4] = 1'b1;
    tick();
    sw[4] = 1'b0;
    tick();
    tick();
    bus.alu_done = 1'b1;
    bus.alu_result = 14'd134;
    tick();
    bus.alu_done = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    check_reset_vals("reset_conv");
    reset = 1'b0;
    bus.alu_done = 1'b1;
    bus.alu_result = 14'd777;
    tick();
    bus.alu_done = 1'b0;
    tick();
    check_disp("stale_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
